// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares data-memory port B between the CPU load/store stage and the DMA/loader
// engine (UART program download, VGA buffer fill). At most one master is
// granted per cycle using bounded round-robin: the last owner keeps the port
// while the other master is also requesting until it has taken MAX_BURST
// consecutive grants, then ownership flips. Read data is captured at the end of
// the grant cycle and returned to the owning master one cycle later.
//
// Parameters:
//   DATA_W    - address / data width in bits
//   MAX_BURST - consecutive grants allowed under contention (1..15)
//
// Ports:
//   clk, reset                       - rising-edge clock, async active-low reset
//   CpuReq/CpuWe/CpuAddr/CpuWdata    - CPU request bundle (held until granted)
//   CpuGnt/CpuStall                  - CPU accepted this cycle / CPU waiting
//   CpuRvalid/CpuRdata               - CPU read return (cycle after grant)
//   DmaReq/DmaWe/DmaAddr/DmaWdata    - DMA request bundle
//   DmaGnt/DmaRvalid/DmaRdata        - DMA grant and read return
//   MemAddress/MemWriteData/MemWriteEn/MemReadData - memory port B
//   Owner                            - 00 idle, 01 CPU, 10 DMA (this cycle)
//   DmaFault                         - guarded DMA access flag (option only)
//
// Build option ARB_DMA_MMIO_GUARD_EN: DMA accesses to 0xFFFFxxxx are granted
// and consumed but never write memory and read back zero; DmaFault pulses in
// the cycle after each such access.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [DATA_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWdata,
  output logic              CpuGnt,
  output logic              CpuStall,
  output logic              CpuRvalid,
  output logic [DATA_W-1:0] CpuRdata,
  input  logic              DmaReq,
  input  logic              DmaWe,
  input  logic [DATA_W-1:0] DmaAddr,
  input  logic [DATA_W-1:0] DmaWdata,
  output logic              DmaGnt,
  output logic              DmaRvalid,
  output logic [DATA_W-1:0] DmaRdata,
  output logic [DATA_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWriteEn,
  input  logic [DATA_W-1:0] MemReadData,
`ifdef ARB_DMA_MMIO_GUARD_EN
  output logic              DmaFault,
`endif
  output logic [1:0]        Owner
);

  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
  localparam logic [3:0] BURST_SAT   = 4'hf;

  logic              last_owner;
  logic [3:0]        burst_cnt;
  logic              rd_pend;
  logic              rd_tag;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  logic [1:0]        grant;
  logic              cpu_gnt;
  logic              dma_gnt;
  logic              cpu_rd;
  logic              dma_rd;
  logic              mmio_hit;

  // Grant decision. Reset is folded in so grants drop the moment reset is
  // asserted rather than at the next edge.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant = OWN_IDLE;
    if (reset) begin
      if (CpuReq && DmaReq) begin
        if (burst_cnt < BURST_LIMIT)
          grant = (last_owner == MST_DMA) ? OWN_DMA : OWN_CPU;
        else
          grant = (last_owner == MST_DMA) ? OWN_CPU : OWN_DMA;
      end else if (CpuReq) begin
        grant = OWN_CPU;
      end else if (DmaReq) begin
        grant = OWN_DMA;
      end
    end
  end

  assign cpu_gnt = (grant == OWN_CPU);
  assign dma_gnt = (grant == OWN_DMA);
  assign cpu_rd  = cpu_gnt & ~CpuWe;
  assign dma_rd  = dma_gnt & ~DmaWe;

`ifdef ARB_DMA_MMIO_GUARD_EN
  assign mmio_hit = dma_gnt & (DmaAddr[31:16] == 16'hffff);
`else
  assign mmio_hit = 1'b0;
`endif

  assign CpuGnt   = cpu_gnt;
  assign DmaGnt   = dma_gnt;
  assign CpuStall = CpuReq & ~cpu_gnt;
  assign Owner    = grant;

  assign MemAddress   = cpu_gnt ? CpuAddr  : (dma_gnt ? DmaAddr  : '0);
  assign MemWriteData = cpu_gnt ? CpuWdata : (dma_gnt ? DmaWdata : '0);
  assign MemWriteEn   = (cpu_gnt & CpuWe) | (dma_gnt & DmaWe & ~mmio_hit);

  // Return path is steered by the tag of the read that was granted last cycle,
  // not by whoever holds the port now, so a new grant cannot steal it.
  assign CpuRvalid = rd_pend & (rd_tag == MST_CPU);
  assign DmaRvalid = rd_pend & (rd_tag == MST_DMA);
  assign CpuRdata  = cpu_rdata_q;
  assign DmaRdata  = dma_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the read-data holding registers are reset as well because the
  // masters observe them directly and must see zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner  <= MST_CPU;
      burst_cnt   <= '0;
      rd_pend     <= 1'b0;
      rd_tag      <= MST_CPU;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (grant == OWN_IDLE) begin
        burst_cnt <= '0;
      end else if (dma_gnt == last_owner) begin
        if (burst_cnt != BURST_SAT) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        last_owner <= dma_gnt;
        burst_cnt  <= 4'd1;
      end

      rd_pend <= cpu_rd | dma_rd;
      rd_tag  <= dma_gnt ? MST_DMA : MST_CPU;
      if (cpu_rd) cpu_rdata_q <= MemReadData;
      if (dma_rd) dma_rdata_q <= mmio_hit ? '0 : MemReadData;
    end
  end

`ifdef ARB_DMA_MMIO_GUARD_EN
  logic fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= mmio_hit;
  end

  assign DmaFault = fault_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares data-memory port B between two masters: the CPU load/store stage and a DMA/loader engine (UART program download, VGA buffer fill).
- Sits between the masters and the memory wrapper's port B signals (address, write data, write enable, read data).
- Grants at most one master per cycle with bounded round-robin, returns registered read data to the owner, and stalls the loser.

Parameters:
- DATA_W, 32, address/data width in bits.
- MAX_BURST, 4, maximum consecutive grants to one master while the other is requesting; range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- CpuReq  in  1  CPU access request, held until granted.
- CpuWe  in  1  CPU write (1) / read (0).
- CpuAddr  in  DATA_W  CPU byte address.
- CpuWdata  in  DATA_W  CPU write data.
- CpuGnt  out  1  CPU access accepted this cycle.
- CpuStall  out  1  CpuReq & ~CpuGnt.
- CpuRvalid  out  1  CPU read data valid.
- CpuRdata  out  DATA_W  CPU read data.
- DmaReq, DmaWe, DmaAddr, DmaWdata  in  1/1/DATA_W/DATA_W  DMA request bundle, same rules as CPU.
- DmaGnt  out  1  DMA access accepted this cycle.
- DmaRvalid  out  1  DMA read data valid.
- DmaRdata  out  DATA_W  DMA read data.
- MemAddress  out  DATA_W  to memory port B address.
- MemWriteData  out  DATA_W  to memory port B write data.
- MemWriteEn  out  1  to memory port B write enable.
- MemReadData  in  DATA_W  from memory port B read data, valid before the next rising edge.
- Owner  out  2  00 idle, 01 CPU, 10 DMA (current-cycle grant).

Behaviour:
- State: LastOwner (CPU/DMA), BurstCnt (4 bits), RdPend (1), RdTag (CPU/DMA), RdData register.
- Reset values: LastOwner=CPU, BurstCnt=0, RdPend=0, all Rvalid=0, Rdata=0.
  - Combinational outputs under reset: Gnt=0, MemWriteEn=0, Owner=00.
- Grant (combinational from requests and state):
  - Only one master requesting: grant it.
  - Both requesting: keep LastOwner if BurstCnt<MAX_BURST, otherwise grant the other master.
  - Neither requesting: no grant, Owner=00.
- Update at rising edge:
  - Grant to LastOwner: BurstCnt saturating +1.
  - Grant to the other master: LastOwner switches, BurstCnt=1.
  - No grant: BurstCnt=0, LastOwner unchanged.
- Mem mux:
  - MemAddress and MemWriteData come from the granted master; zero when idle.
  - MemWriteEn = Gnt & We of the granted master.
- Read latency:
  - Read granted in cycle N: MemReadData is captured at the end of N.
  - The owner's Rvalid=1 and Rdata=captured value for exactly cycle N+1.
  - The other master's Rvalid stays 0. Rdata holds its last value.
- Back-to-back reads: one per cycle, fully pipelined, no bubbles.
- Writes produce no Rvalid.
- Simultaneous events:
  - A CPU read in N+1 does not disturb a DMA Rvalid in N+1.
  - Each Rvalid is driven by RdTag, not by the current grant.
- Reset mid-operation: a pending Rvalid is dropped and the grant deasserts immediately (async).
- Requests must stay stable while stalled. Changing them while stalled is illegal; arbitration then follows the new values.

Optional Feature:
- ARB_DMA_MMIO_GUARD_EN:
  - Defined: a DMA access with DmaAddr[31:16]==16'hffff is granted and consumed, but MemWriteEn is forced to 0.
  - A guarded DMA read returns DmaRdata=0 with DmaRvalid in N+1.
  - Output DmaFault (1 bit) pulses high for one cycle (N+1) on each guarded access; reset value 0.
  - Undefined: no address check, DmaFault port absent, and DMA accesses to MMIO addresses pass through unchanged.

Test Plan:
- Reset released, CpuReq=1, CpuWe=0, CpuAddr=0x10, MemReadData=0xDEADBEEF -> CpuGnt=1 in cycle 0; CpuRvalid=1 and CpuRdata=0xDEADBEEF in cycle 1; DmaRvalid=0.
- Both masters request reads continuously, MAX_BURST=4, LastOwner=CPU -> grant pattern CPU×4, DMA×4, CPU×4; each loser has Stall=1 during the other's burst.
- CPU write addr=0x20 data=0x55 in the same cycle the DMA requests -> MemWriteEn=1, MemAddress=0x20, MemWriteData=0x55, DmaGnt=0; DMA granted next cycle.
- DMA read in cycle 5, CPU read in cycle 6 -> DmaRvalid=1 only in cycle 6, CpuRvalid=1 only in cycle 7, each with the correct data.
- reset asserted low while a read is pending -> all Gnt, Rvalid and MemWriteEn go 0 immediately; after release, BurstCnt=0 and LastOwner=CPU.
- With ARB_DMA_MMIO_GUARD_EN: DMA write to 0xFFFF0004 -> DmaGnt=1, MemWriteEn=0, DmaFault=1 the next cycle; DMA read of the same address -> DmaRdata=0.
